// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter; accepts the core's output_en/output_data
// stream and reports backpressure through a registered FIFO-full flag.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       uart_txd,
    output logic       tx_idle
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             push;
    logic             pop;
    logic             fifo_empty;

    state_t           state;
    state_t           state_d;
    logic [BAUD_W-1:0] baud;
    logic [BAUD_W-1:0] baud_d;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_d;
    logic [7:0]       shift;
    logic [7:0]       shift_d;
    logic             txd_d;
    logic             baud_last;

    // tx_busy is exactly "FIFO full", so gating on it never overflows the FIFO.
    assign push       = tx_en && !tx_busy;
    assign fifo_empty = (count == '0);
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);
    assign baud_last  = (baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign tx_idle    = fifo_empty && (state == IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            tx_busy <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count   <= count_next;
            tx_busy <= (count_next == CNT_W'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            uart_txd <= 1'b1;
        end else begin
            state    <= state_d;
            baud     <= baud_d;
            bit_idx  <= bit_d;
            shift    <= shift_d;
            uart_txd <= txd_d;
        end
    end

    always_comb begin
        state_d = state;
        baud_d  = baud;
        bit_d   = bit_idx;
        shift_d = shift;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    baud_d = baud + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_idx == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        shift_d = {1'b0, shift[7:1]};
                        bit_d   = bit_idx + 3'd1;
                    end
                end else begin
                    baud_d = baud + 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    // Chain straight into the next frame so bursts have no idle gap.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is registered from the next state so it changes on the same edge.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: every line cycle of every frame is compared
// against a scoreboard of expected bytes.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_en = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_busy;
    logic       uart_txd;
    logic       tx_idle;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic       saw_low;

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_en   (tx_en),
        .tx_data (tx_data),
        .tx_busy (tx_busy),
        .uart_txd(uart_txd),
        .tx_idle (tx_idle)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        tx_en   = 1'b1;
        tx_data = d;
        exp_q.push_back(d);
        tick();
    endtask

    task automatic next_byte(output logic [7:0] d);
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        d = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    endtask

    // Checks frame cycles lo..hi-1; cycle 0 is the first cycle of the start bit.
    task automatic check_frame(input logic [7:0] d, input int lo, input int hi);
        for (int j = lo; j < hi; j++) begin
            int   i;
            logic lvl;
            i = j / CPB;
            if (i == 0)      lvl = 1'b0;
            else if (i == 9) lvl = 1'b1;
            else             lvl = d[i-1];
            check($sformatf("txd_%02h_c%0d", d, j), 32'(uart_txd), 32'(lvl));
            tick();
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", 32'(uart_txd), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_idle", 32'(tx_idle), 32'd1);
        rst = 1'b1;
        tick();
        check("rel_idle", 32'(tx_idle), 32'd1);

        // Single byte 0x42 with 2-cycle latency
        write_byte(8'h42);
        tx_en = 1'b0;
        check("lat_k1_txd", 32'(uart_txd), 32'd1);
        check("lat_k1_idle", 32'(tx_idle), 32'd0);
        tick();
        next_byte(b);
        check_frame(b, 0, FRAME - 1);
        check("single_idle_last", 32'(tx_idle), 32'd0);
        check_frame(b, FRAME - 1, FRAME);
        check("single_idle_end", 32'(tx_idle), 32'd1);
        check("single_txd_end", 32'(uart_txd), 32'd1);

        // Burst of five, then a dropped write while full
        repeat (3) tick();
        for (int i = 0; i < 5; i++) begin
            write_byte(8'(8'h30 + i));
            if (i == 3) check("burst_busy_e3", 32'(tx_busy), 32'd0);
        end
        check("burst_busy_e4", 32'(tx_busy), 32'd1);
        tx_data = 8'hFF;
        tick();
        tx_en = 1'b0;
        check("drop_busy_hold", 32'(tx_busy), 32'd1);
        next_byte(b);
        check_frame(b, 4, FRAME);
        check("busy_fall", 32'(tx_busy), 32'd0);
        repeat (4) begin
            next_byte(b);
            check_frame(b, 0, FRAME);
        end
        check("burst_idle", 32'(tx_idle), 32'd1);
        check("burst_sb_empty", 32'(exp_q.size()), 32'd0);

        // Push and pop at the STOP-final edge
        repeat (3) tick();
        write_byte(8'h41);
        write_byte(8'h62);
        write_byte(8'hC3);
        tx_en = 1'b0;
        next_byte(b);
        check_frame(b, 1, FRAME - 1);
        tx_en   = 1'b1;
        tx_data = 8'h5A;
        exp_q.push_back(8'h5A);
        check_frame(b, FRAME - 1, FRAME);
        tx_en = 1'b0;
        check("pp_busy", 32'(tx_busy), 32'd0);
        repeat (3) begin
            next_byte(b);
            check_frame(b, 0, FRAME);
        end
        check("pp_idle", 32'(tx_idle), 32'd1);

        // Reset during DATA bit 3 with two bytes queued
        repeat (3) tick();
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        tx_en = 1'b0;
        next_byte(b);
        check_frame(b, 1, 16);
        check("pre_rst_txd", 32'(uart_txd), 32'd0);
        check("pre_rst_idle", 32'(tx_idle), 32'd0);
        rst = 1'b0;
        #2;
        check("mid_rst_txd", 32'(uart_txd), 32'd1);
        check("mid_rst_idle", 32'(tx_idle), 32'd1);
        check("mid_rst_busy", 32'(tx_busy), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        exp_q.delete();
        saw_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (uart_txd !== 1'b1) saw_low = 1'b1;
        end
        check("post_rst_line_high", 32'(saw_low), 32'd0);
        check("post_rst_idle", 32'(tx_idle), 32'd1);

        // Core-style handshake: write, wait a cycle, recheck busy
        for (int i = 0; i < 3; i++) begin
            check("core_busy", 32'(tx_busy), 32'd0);
            write_byte(8'h42);
            tx_en = 1'b0;
            tick();
        end
        next_byte(b);
        check_frame(b, 4, FRAME);
        repeat (2) begin
            next_byte(b);
            check_frame(b, 0, FRAME);
        end
        check("core_idle", 32'(tx_idle), 32'd1);
        check("core_busy_end", 32'(tx_busy), 32'd0);
        check("core_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
